// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the MIPS pipeline (master) and its hazard control unit (slave).
// With HAZARD_PERF_CNT_EN defined the bundle also carries the performance counters.
interface hazard_control_unit_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        pipe_hold;
    logic        mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] wait_cnt;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_err
`ifdef HAZARD_PERF_CNT_EN
        , input stall_cnt, flush_cnt, wait_cnt
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_err
`ifdef HAZARD_PERF_CNT_EN
        , output stall_cnt, flush_cnt, wait_cnt
`endif
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage MIPS core: load-use bubbles, branch flushes, memory holds.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_control_unit #(
    parameter int BRANCH_PENALTY = 1,
    parameter int MEM_TIMEOUT    = 15,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_control_unit_if.slave  hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [2:0]       BR_RELOAD = 3'(BRANCH_PENALTY - 1);
    localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [2:0]       br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    logic lu;
    logic mem_stall;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_err;

    always_comb begin
        lu = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
             ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
        mem_stall = hz.mem_req && !hz.mem_ready;

        state_d     = state_q;
        br_cnt_d    = br_cnt_q;
        to_cnt_d    = to_cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_hold   = 1'b0;
        mem_err     = 1'b0;

        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = RUN;
            br_cnt_d    = 3'd0;
            to_cnt_d    = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        pipe_hold   = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        to_cnt_d    = CNT_W'(1);
                        state_d     = MEM_WAIT;
                    end else if (hz.branch_taken) begin
                        // The branch itself sits in ID, so any load-use match is moot.
                        if_id_flush = 1'b1;
                        if (BRANCH_PENALTY > 1) begin
                            br_cnt_d = BR_RELOAD;
                            state_d  = FLUSH;
                        end
                    end else if (lu) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                FLUSH: begin
                    if (mem_stall) begin
                        // Freeze the flush sequence; br_cnt survives the wait.
                        pipe_hold   = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        to_cnt_d    = CNT_W'(1);
                        state_d     = MEM_WAIT;
                    end else begin
                        if_id_flush = 1'b1;
                        br_cnt_d    = br_cnt_q - 3'd1;
                        if (br_cnt_q == 3'd1) begin
                            state_d = RUN;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (hz.mem_ready) begin
                        to_cnt_d = '0;
                        state_d  = (br_cnt_q != 3'd0) ? FLUSH : RUN;
                    end else begin
                        pipe_hold   = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        if (to_cnt_q >= TO_MAX) begin
                            // Abandon the access and any pending flush sequence.
                            mem_err  = 1'b1;
                            to_cnt_d = '0;
                            br_cnt_d = 3'd0;
                            state_d  = RUN;
                        end else begin
                            to_cnt_d = to_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            br_cnt_q <= 3'd0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            br_cnt_q <= br_cnt_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.if_id_write = if_id_write;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.pipe_hold   = pipe_hold;
    assign hz.mem_err     = mem_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] wait_cnt_q,  wait_cnt_d;

    // id_ex_flush outside reset is only ever a load-use bubble.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, id_ex_flush};
        flush_cnt_d = flush_cnt_q + {31'd0, if_id_flush};
        wait_cnt_d  = wait_cnt_q  + {31'd0, (state_q == MEM_WAIT)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
    assign hz.wait_cnt  = wait_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit (BRANCH_PENALTY=3, MEM_TIMEOUT=15).
// Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_err}.
module tb_hazard_control_unit;
    logic clk = 1'b0;
    logic reset;

    hazard_control_unit_if hif();

    hazard_control_unit #(
        .BRANCH_PENALTY (3),
        .MEM_TIMEOUT    (15),
        .CNT_W          (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] E_RST  = 6'b001100;
    localparam logic [5:0] E_RUN  = 6'b110000;
    localparam logic [5:0] E_LU   = 6'b000100;
    localparam logic [5:0] E_BR   = 6'b111000;
    localparam logic [5:0] E_HOLD = 6'b000010;
    localparam logic [5:0] E_ERR  = 6'b000011;

    typedef struct {
        logic [5:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic step(input logic rst, input logic br, input logic mreq, input logic mrdy,
                        input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt,
                        input logic [5:0] exp, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset            = rst;
        hif.branch_taken = br;
        hif.mem_req      = mreq;
        hif.mem_ready    = mrdy;
        hif.ex_mem_read  = mr;
        hif.ex_rt        = ert;
        hif.id_rs        = rs;
        hif.id_rt        = rt;
        hif.id_uses_rt   = urt;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [5:0] exp, input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, exp, tag);
    endtask

    task automatic rst_cycle(input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, E_RST, tag);
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [5:0] got;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {hif.pc_write, hif.if_id_write, hif.if_id_flush,
                   hif.id_ex_flush, hif.pipe_hold, hif.mem_err};
            n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.tag, got, e.exp);
            end else begin
                $display("ok   %s: outputs %b", e.tag, got);
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    task automatic check_perf(input logic [31:0] s, input logic [31:0] f,
                              input logic [31:0] w, input string tag);
        n_checks++;
        if (hif.stall_cnt !== s || hif.flush_cnt !== f || hif.wait_cnt !== w) begin
            n_fail++;
            $display("FAIL %s: stall/flush/wait got %0d/%0d/%0d expected %0d/%0d/%0d",
                     tag, hif.stall_cnt, hif.flush_cnt, hif.wait_cnt, s, f, w);
        end else begin
            $display("ok   %s: stall/flush/wait %0d/%0d/%0d", tag, s, f, w);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        hif.branch_taken = 1'b0;
        hif.mem_req      = 1'b0;
        hif.mem_ready    = 1'b0;
        hif.ex_mem_read  = 1'b0;
        hif.ex_rt        = 5'd0;
        hif.id_rs        = 5'd0;
        hif.id_rt        = 5'd0;
        hif.id_uses_rt   = 1'b0;

        for (int i = 0; i < 3; i++) rst_cycle($sformatf("reset_%0d", i));
        idle(E_RUN, "idle_after_reset_0");
        idle(E_RUN, "idle_after_reset_1");

        // Load-use variants
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, E_LU,  "lu_rs_match");
        idle(E_RUN, "lu_cleared");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, E_RUN, "lu_rt_zero");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, E_RUN, "lu_rt_unused");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, E_LU,  "lu_rt_used");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, E_RUN, "no_load_in_ex");

        // Branch: three flush cycles, load-use and extra branch ignored in FLUSH
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, E_BR, "branch_c1");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, E_BR, "branch_c2_lu");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, E_BR, "branch_c3_lu");
        idle(E_RUN, "branch_done");

        // Memory wait: four not-ready cycles then ready
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD,
                 $sformatf("mem_wait_%0d", i));
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, E_RUN, "mem_ready");
        idle(E_RUN, "after_mem_ready");

        // Timeout: stall cycle in RUN plus 14 MEM_WAIT cycles, error on the 15th
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD,
                 $sformatf("timeout_hold_%0d", i));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, E_ERR, "timeout_err");
        idle(E_RUN, "after_timeout_run");

        // Reset during a wait aborts it silently
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD,
                 $sformatf("abort_hold_%0d", i));
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, E_RST, "abort_reset");
        idle(E_RUN, "abort_run");

        // Branch together with load-use: branch wins, no bubble
        rst_cycle("perf_reset");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, E_BR, "br_lu_c1");
        idle(E_BR, "br_lu_c2");
        idle(E_BR, "br_lu_c3");
        idle(E_RUN, "br_lu_done");
`ifdef HAZARD_PERF_CNT_EN
        check_perf(32'd0, 32'd3, 32'd0, "perf_br_lu");
`endif

        // Memory stall mid-flush keeps the remaining flush count
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, E_BR,   "fl_mem_c1");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD, "fl_mem_freeze");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, E_RUN,  "fl_mem_ready");
        idle(E_BR, "fl_mem_c2");
        idle(E_BR, "fl_mem_c3");
        idle(E_RUN, "fl_mem_done");
`ifdef HAZARD_PERF_CNT_EN
        check_perf(32'd0, 32'd6, 32'd1, "perf_fl_mem");
`endif

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
